sbox_scheduler: RTL and testbench
=================================

# sbox_scheduler

Time-multiplexes one SubBytes S-box lookup between the two AES consumers that need byte substitution: key expansion (SubWord, 4 bytes) and the round datapath (SubBytes, 16 bytes). Each requester uses a valid/ready request channel and a valid/ready response channel. The block arbitrates between them, feeds the granted operand through the single S-box one byte per cycle, and returns the assembled result. It sits between the key-expansion unit, the round controller and one S-box instance, replacing the twenty S-box copies a fully parallel design would need.

## Interface
- KE_PRIORITY, default 0: 0 = round-robin between requesters; 1 = key expansion always wins simultaneous requests.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- ke_req_valid  in  1  key-expansion word request.
- ke_req_word  in  32  word to substitute.
- ke_req_ready  out  1  request accepted when valid && ready.
- ke_rsp_valid  out  1  substituted word available; held until ke_rsp_ready.
- ke_rsp_word  out  32  SubWord result.
- ke_rsp_ready  in  1  consumer takes response.
- dp_req_valid  in  1  datapath state request.
- dp_req_state  in  128  state to substitute.
- dp_req_ready  out  1  request accepted when valid && ready.
- dp_rsp_valid  out  1  substituted state available; held until dp_rsp_ready.
- dp_rsp_state  out  128  SubBytes result.
- dp_rsp_ready  in  1  consumer takes response.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, RUN, HOLD.
- IDLE:
  - Arbitrate among asserted req_valid signals.
  - Assert ready only to the winner; ready is combinational from valid and arbitration state.
  - On handshake: capture the operand into the operand register, clear the result register, record owner (KE/DP), set byte counter = 0, go to RUN.
- Arbitration:
  - Single requester always wins.
  - On a tie with KE_PRIORITY=1: KE wins.
  - On a tie with KE_PRIORITY=0: the requester not granted last wins. The last-grant flag resets to DP, so KE wins the first tie after reset.
- RUN:
  - Byte k = operand bits [8k+7:8k]. Byte k goes to the S-box in cycle k of RUN.
  - The S-box output is registered into result byte k at the same clock edge.
  - Counter is 4 bits. Terminal count is 3 for KE and 15 for DP.
  - At terminal count go to HOLD.
- HOLD:
  - Owner's rsp_valid = 1 and rsp_word/rsp_state = result register. Other owner's rsp_valid = 0.
  - On rsp_ready go to IDLE.
- Request stability: a requester must hold valid and data stable until ready. The operand is captured at acceptance; later input changes are ignored.
- Requests arriving while not in IDLE wait; both ready outputs stay 0.
- Reset values: state IDLE, counter 0, operand/result registers 0, last-grant DP. All ready, rsp_valid and busy outputs 0. Response data outputs 0.
- Reset asserted mid-RUN or mid-HOLD: the operation is discarded and no response is produced. State is IDLE on the first cycle after reset is released.
- rsp_valid high with rsp_ready low: stay in HOLD indefinitely, output stable, no new grants.

## Timing
- Request accepted at cycle T:
  - KE: RUN during T+1..T+4; ke_rsp_valid first high at T+5.
  - DP: RUN during T+1..T+16; dp_rsp_valid first high at T+17.
- rsp_ready high in the first HOLD cycle gives one HOLD cycle. IDLE follows on the next cycle and a new acceptance is possible in that IDLE cycle.
- Best-case throughput: one KE word per 6 cycles; one DP state per 18 cycles.
- No combinational path from any req input to any rsp output. Only req_valid → req_ready is combinational.

## Structure
- Shared package/include aes_pkg holds:
  - KE_BYTES = 4, DP_BYTES = 16.
  - Scheduler state encoding (IDLE/RUN/HOLD).
  - Owner encoding (OWN_KE = 0, OWN_DP = 1).
- One sub-module: a single instance of the existing SubBytes combinational lookup (8-bit in, 8-bit out). Its clk port is tied to clk but unused.
- Operand and result registers are 128 bits wide. KE uses only the low 32 bits.

## Test plan
- Reset, then KE request 32'hcf4f3c09 with rsp_ready = 1:
  - ke_req_ready high in the acceptance cycle T.
  - ke_rsp_valid at T+5 with ke_rsp_word = 32'h8a84eb01.
  - busy high for T+1..T+5.
- DP request 128'h00102030405060708090a0b0c0d0e0f0:
  - dp_rsp_valid at T+17 with dp_rsp_state = 128'h63cab7040953d051cd60e0e7ba70e18c.
- Simultaneous KE and DP valid, KE_PRIORITY=0, held continuously over three transactions:
  - Grants in order KE, DP, KE.
  - With KE_PRIORITY=1: KE, KE, KE.
- Backpressure: hold dp_rsp_ready = 0 for 10 cycles with a KE request pending.
  - dp_rsp_state stays stable and ke_req_ready stays 0.
  - After dp_rsp_ready pulses, KE is accepted in the next IDLE cycle.
- Reset mid-RUN: assert rst_n = 0 at RUN cycle 7 of a DP request.
  - All outputs 0 on the next cycle.
  - No dp_rsp_valid afterwards.
  - A fresh KE request 32'h00000000 then returns 32'h63636363.
- Input change after accept: change ke_req_word to 32'hffffffff one cycle after acceptance of 32'h01010101.
  - Result is 32'h7c7c7c7c.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES definitions for the S-box scheduler slice.
//   - operand byte counts for key expansion (SubWord) and the round datapath
//   - scheduler state and owner encodings
//   - GF(2^8) helpers that implement the SubBytes lookup arithmetically
package aes_pkg;

  localparam int KE_BYTES = 4;
  localparam int DP_BYTES = 16;

  // Terminal counts of the 4-bit byte counter.
  localparam logic [3:0] KE_LAST = 4'(KE_BYTES - 1);
  localparam logic [3:0] DP_LAST = 4'(DP_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } sched_state_e;

  typedef enum logic {
    OWN_KE = 1'b0,
    OWN_DP = 1'b1
  } owner_e;

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1 (shift-and-add form).
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? (p ^ x) : p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as SubBytes requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] t;
    logic [7:0] p;
    t = a;
    p = 8'h01;
    for (int i = 1; i < 8; i++) begin
      t = gf_mul(t, t);   // t = a^(2^i)
      p = gf_mul(p, t);   // accumulates a^(2+4+...+128) = a^254
    end
    return p;
  endfunction

  // SubBytes: inverse followed by the affine transform b ^ rotl1..rotl4 ^ 0x63.
  function automatic logic [7:0] sbox_byte(input logic [7:0] a);
    logic [7:0] v;
    v = gf_inv(a);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^
           {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/sbox_scheduler_sbox.sv
// sbox_scheduler_sbox: single combinational SubBytes lookup.
// Ports:
//   clk   in  1  present for interface compatibility; not used
//   din   in  8  byte to substitute
//   dout  out 8  S-box(din)
module sbox_scheduler_sbox
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic [7:0] din,
  output logic [7:0] dout
);

  logic unused_clk_s;

  assign unused_clk_s = clk;
  assign dout         = sbox_byte(din);

endmodule

// File: rtl/sbox_scheduler.sv
// sbox_scheduler: shares one S-box between key expansion (4-byte SubWord)
// and the round datapath (16-byte SubBytes). One byte is substituted per
// cycle; the assembled result is held until the owner takes it.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   ke_req_valid/ready, ke_req_word key-expansion request (32 bit)
//   ke_rsp_valid/ready, ke_rsp_word key-expansion response (32 bit)
//   dp_req_valid/ready, dp_req_state datapath request (128 bit)
//   dp_rsp_valid/ready, dp_rsp_state datapath response (128 bit)
//   busy                            high whenever not IDLE
// Parameter KE_PRIORITY: 0 = round-robin on ties, 1 = key expansion wins ties.
module sbox_scheduler
  import aes_pkg::*;
#(
  parameter logic KE_PRIORITY = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ke_req_valid,
  input  logic [31:0]  ke_req_word,
  output logic         ke_req_ready,
  output logic         ke_rsp_valid,
  output logic [31:0]  ke_rsp_word,
  input  logic         ke_rsp_ready,
  input  logic         dp_req_valid,
  input  logic [127:0] dp_req_state,
  output logic         dp_req_ready,
  output logic         dp_rsp_valid,
  output logic [127:0] dp_rsp_state,
  input  logic         dp_rsp_ready,
  output logic         busy
);

  sched_state_e state_r;
  sched_state_e state_nxt_s;
  owner_e       owner_r;
  owner_e       last_grant_r;
  logic [3:0]   cnt_r;
  logic [127:0] operand_r;
  logic [127:0] result_r;

  logic         ke_win_s;
  logic         dp_win_s;
  logic [3:0]   last_cnt_s;
  logic         own_rsp_ready_s;
  logic [6:0]   byte_idx_s;
  logic [7:0]   sbox_in_s;
  logic [7:0]   sbox_out_s;

  // Tie-break: fixed KE priority, or grant whoever did not win last time.
  always_comb begin
    ke_win_s = 1'b0;
    dp_win_s = 1'b0;
    if (ke_req_valid && dp_req_valid) begin
      if (KE_PRIORITY || (last_grant_r == OWN_DP)) begin
        ke_win_s = 1'b1;
      end else begin
        dp_win_s = 1'b1;
      end
    end else begin
      ke_win_s = ke_req_valid;
      dp_win_s = dp_req_valid;
    end
  end

  // Grants are only offered from IDLE; everything else waits.
  assign ke_req_ready = (state_r == IDLE) && ke_win_s;
  assign dp_req_ready = (state_r == IDLE) && dp_win_s;

  assign last_cnt_s      = (owner_r == OWN_KE) ? KE_LAST : DP_LAST;
  assign own_rsp_ready_s = (owner_r == OWN_KE) ? ke_rsp_ready : dp_rsp_ready;

  // Byte k of the operand is looked up while the counter holds k.
  assign byte_idx_s = {cnt_r, 3'b000};
  assign sbox_in_s  = operand_r[byte_idx_s +: 8];

  sbox_scheduler_sbox u_sbox (
    .clk  (clk),
    .din  (sbox_in_s),
    .dout (sbox_out_s)
  );

  // Next-state logic for the IDLE/RUN/HOLD sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (ke_req_ready || dp_req_ready) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == last_cnt_s) begin
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = RUN;
        end
      end
      HOLD: begin
        if (own_rsp_ready_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand capture, per-byte result fill, owner and last-grant tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      operand_r    <= 128'd0;
      result_r     <= 128'd0;
      cnt_r        <= 4'd0;
      owner_r      <= OWN_KE;
      last_grant_r <= OWN_DP;
    end else begin
      case (state_r)
        IDLE: begin
          if (ke_req_ready) begin
            operand_r    <= {96'd0, ke_req_word};
            result_r     <= 128'd0;
            cnt_r        <= 4'd0;
            owner_r      <= OWN_KE;
            last_grant_r <= OWN_KE;
          end else if (dp_req_ready) begin
            operand_r    <= dp_req_state;
            result_r     <= 128'd0;
            cnt_r        <= 4'd0;
            owner_r      <= OWN_DP;
            last_grant_r <= OWN_DP;
          end
        end
        RUN: begin
          result_r[byte_idx_s +: 8] <= sbox_out_s;
          cnt_r                     <= cnt_r + 4'd1;
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // Response outputs decode registered state only; no path from req inputs.
  assign ke_rsp_valid = (state_r == HOLD) && (owner_r == OWN_KE);
  assign dp_rsp_valid = (state_r == HOLD) && (owner_r == OWN_DP);
  assign ke_rsp_word  = result_r[31:0];
  assign dp_rsp_state = result_r;
  assign busy         = (state_r != IDLE);

endmodule

// File: tb/tb_sbox_scheduler.sv
// Self-checking bench for sbox_scheduler: directed vector table, randomized
// transactions against an independent S-box model, and hand sequences for
// arbitration, backpressure, mid-run reset and post-accept input changes.
module tb_sbox_scheduler;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ke_req_valid, ke_req_ready, ke_rsp_valid, ke_rsp_ready;
  logic [31:0]  ke_req_word, ke_rsp_word;
  logic         dp_req_valid, dp_req_ready, dp_rsp_valid, dp_rsp_ready;
  logic [127:0] dp_req_state, dp_rsp_state;
  logic         busy;

  logic         p_ke_req_valid, p_ke_req_ready, p_ke_rsp_valid, p_ke_rsp_ready;
  logic [31:0]  p_ke_req_word, p_ke_rsp_word;
  logic         p_dp_req_valid, p_dp_req_ready, p_dp_rsp_valid, p_dp_rsp_ready;
  logic [127:0] p_dp_req_state, p_dp_rsp_state;
  logic         p_busy;

  int checks = 0;
  int failures = 0;
  logic [7:0] sb_ref [256];

  always #5 clk = ~clk;

  sbox_scheduler #(.KE_PRIORITY(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .ke_req_valid(ke_req_valid), .ke_req_word(ke_req_word), .ke_req_ready(ke_req_ready),
    .ke_rsp_valid(ke_rsp_valid), .ke_rsp_word(ke_rsp_word), .ke_rsp_ready(ke_rsp_ready),
    .dp_req_valid(dp_req_valid), .dp_req_state(dp_req_state), .dp_req_ready(dp_req_ready),
    .dp_rsp_valid(dp_rsp_valid), .dp_rsp_state(dp_rsp_state), .dp_rsp_ready(dp_rsp_ready),
    .busy(busy)
  );

  sbox_scheduler #(.KE_PRIORITY(1'b1)) dut_pri (
    .clk(clk), .rst_n(rst_n),
    .ke_req_valid(p_ke_req_valid), .ke_req_word(p_ke_req_word), .ke_req_ready(p_ke_req_ready),
    .ke_rsp_valid(p_ke_rsp_valid), .ke_rsp_word(p_ke_rsp_word), .ke_rsp_ready(p_ke_rsp_ready),
    .dp_req_valid(p_dp_req_valid), .dp_req_state(p_dp_req_state), .dp_req_ready(p_dp_req_ready),
    .dp_rsp_valid(p_dp_rsp_valid), .dp_rsp_state(p_dp_rsp_state), .dp_rsp_ready(p_dp_rsp_ready),
    .busy(p_busy)
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    logic [14:0] poly;
    p = 15'd0;
    poly = 15'h11b;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (poly << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] ref_sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] c;
    logic [7:0] r;
    inv = 8'h00;
    c = 8'h63;
    for (int y = 1; y < 256; y++) if (ref_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
    for (int i = 0; i < 8; i++)
      r[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
    return r;
  endfunction

  function automatic logic [127:0] model_sub(input logic [127:0] op, input int nbytes);
    logic [127:0] r;
    r = 128'd0;
    for (int k = 0; k < nbytes; k++) r[8*k +: 8] = sb_ref[op[8*k +: 8]];
    return r;
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    ke_req_valid = 1'b0; ke_req_word = 32'd0; ke_rsp_ready = 1'b1;
    dp_req_valid = 1'b0; dp_req_state = 128'd0; dp_rsp_ready = 1'b1;
    p_ke_req_valid = 1'b0; p_ke_req_word = 32'd0; p_ke_rsp_ready = 1'b1;
    p_dp_req_valid = 1'b0; p_dp_req_state = 128'd0; p_dp_rsp_ready = 1'b1;
    step;
    step;
    rst_n = 1'b1;
  endtask

  // One full transaction on the round-robin DUT with rsp_ready held high.
  // lat is the cycle offset (from acceptance) at which rsp_valid is first seen.
  task automatic txn(input bit dp, input logic [127:0] op, output logic [127:0] res,
                     output int lat, output bit busy_ok);
    int n;
    busy_ok = 1'b1;
    res = 128'd0;
    lat = -1;
    step;
    if (dp) begin dp_req_valid = 1'b1; dp_req_state = op; end
    else begin ke_req_valid = 1'b1; ke_req_word = op[31:0]; end
    #1;
    n = 0;
    while (!(dp ? dp_req_ready : ke_req_ready) && n < 60) begin step; #1; n++; end
    if (!(dp ? dp_req_ready : ke_req_ready)) begin
      checks++; failures++;
      $display("FAIL txn_accept_timeout actual=no_ready required=ready");
      dp_req_valid = 1'b0; ke_req_valid = 1'b0;
      return;
    end
    if (busy) busy_ok = 1'b0;
    step;
    // Inputs change right after acceptance; result must use captured operand.
    dp_req_valid = 1'b0; ke_req_valid = 1'b0;
    dp_req_state = {128{1'b1}}; ke_req_word = 32'hffffffff;
    lat = 1;
    #1;
    while (!(dp ? dp_rsp_valid : ke_rsp_valid) && lat < 40) begin
      if (!busy) busy_ok = 1'b0;
      step; #1; lat++;
    end
    if (!busy) busy_ok = 1'b0;
    res = dp ? dp_rsp_state : {96'd0, ke_rsp_word};
    step;
    #1;
    if (busy) busy_ok = 1'b0;
  endtask

  // Both requesters held valid; record the order of the first three grants.
  task automatic arb_run(input bit pri, output logic [2:0] order, output int cnt, output bit both);
    int n;
    order = 3'b000; cnt = 0; both = 1'b0; n = 0;
    step;
    if (pri) begin
      p_ke_req_valid = 1'b1; p_dp_req_valid = 1'b1;
      p_ke_req_word = 32'h01234567; p_dp_req_state = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    end else begin
      ke_req_valid = 1'b1; dp_req_valid = 1'b1;
      ke_req_word = 32'h01234567; dp_req_state = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    end
    #1;
    while (cnt < 3 && n < 150) begin
      logic kr, dr;
      kr = pri ? p_ke_req_ready : ke_req_ready;
      dr = pri ? p_dp_req_ready : dp_req_ready;
      if (kr && dr) both = 1'b1;
      if (kr || dr) begin order[cnt] = dr; cnt++; end
      step; #1; n++;
    end
    ke_req_valid = 1'b0; dp_req_valid = 1'b0;
    p_ke_req_valid = 1'b0; p_dp_req_valid = 1'b0;
    repeat (20) step;
  endtask

  typedef struct {
    bit           dp;
    logic [127:0] op;
    logic [127:0] exp;
  } vec_t;

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    logic [127:0] res, op, expv;
    int lat, cnt, bad;
    bit busy_ok, both, dp;
    logic [2:0] order;

    for (int i = 0; i < 256; i++) sb_ref[i] = ref_sbox(8'(i));

    vecs[0] = '{1'b0, 128'hcf4f3c09, 128'h8a84eb01};
    vecs[1] = '{1'b1, 128'h00102030405060708090a0b0c0d0e0f0,
                      128'h63cab7040953d051cd60e0e7ba70e18c};
    vecs[2] = '{1'b0, 128'h00000000, 128'h63636363};
    vecs[3] = '{1'b0, 128'h01010101, 128'h7c7c7c7c};
    vecs[4] = '{1'b1, {128{1'b1}}, {16{8'h16}}};

    // Reset state.
    do_reset;
    #1;
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_ke_rsp_valid", 128'(ke_rsp_valid), 128'd0);
    chk("reset_dp_rsp_valid", 128'(dp_rsp_valid), 128'd0);
    chk("reset_ke_req_ready", 128'(ke_req_ready), 128'd0);
    chk("reset_dp_req_ready", 128'(dp_req_ready), 128'd0);
    chk("reset_ke_rsp_word", 128'(ke_rsp_word), 128'd0);
    chk("reset_dp_rsp_state", dp_rsp_state, 128'd0);

    // Directed vector table.
    for (int i = 0; i < 5; i++) begin
      txn(vecs[i].dp, vecs[i].op, res, lat, busy_ok);
      chk($sformatf("vec%0d_data", i), res, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), 128'(lat), vecs[i].dp ? 128'd17 : 128'd5);
      chk($sformatf("vec%0d_busy", i), 128'(busy_ok), 128'd1);
    end

    // Randomized transactions against the model.
    for (int i = 0; i < 16; i++) begin
      dp = 1'($urandom_range(0, 1));
      op = {$urandom, $urandom, $urandom, $urandom};
      if (!dp) op[127:32] = 96'd0;
      expv = model_sub(op, dp ? 16 : 4);
      txn(dp, op, res, lat, busy_ok);
      chk($sformatf("rand%0d_data", i), res, expv);
      chk($sformatf("rand%0d_latency", i), 128'(lat), dp ? 128'd17 : 128'd5);
    end

    // Arbitration: round-robin then fixed priority, from fresh reset.
    do_reset;
    arb_run(1'b0, order, cnt, both);
    chk("rr_grant_count", 128'(cnt), 128'd3);
    chk("rr_grant_order", 128'(order), 128'(3'b010));
    chk("rr_both_ready", 128'(both), 128'd0);
    do_reset;
    arb_run(1'b1, order, cnt, both);
    chk("pri_grant_count", 128'(cnt), 128'd3);
    chk("pri_grant_order", 128'(order), 128'(3'b000));
    chk("pri_both_ready", 128'(both), 128'd0);

    // Backpressure on DP response with a KE request waiting.
    do_reset;
    op = 128'h3243f6a8885a308d313198a2e0370734;
    expv = model_sub(op, 16);
    step;
    dp_rsp_ready = 1'b0; dp_req_valid = 1'b1; dp_req_state = op;
    #1;
    chk("bp_dp_accept", 128'(dp_req_ready), 128'd1);
    step;
    dp_req_valid = 1'b0; ke_req_valid = 1'b1; ke_req_word = 32'hcf4f3c09;
    #1;
    cnt = 0;
    while (!dp_rsp_valid && cnt < 40) begin step; #1; cnt++; end
    chk("bp_dp_rsp_arrives", 128'(dp_rsp_valid), 128'd1);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bp_state_c%0d", i), dp_rsp_state, expv);
      chk($sformatf("bp_ke_ready_c%0d", i), 128'(ke_req_ready), 128'd0);
      chk($sformatf("bp_dp_valid_c%0d", i), 128'(dp_rsp_valid), 128'd1);
      step; #1;
    end
    dp_rsp_ready = 1'b1;
    step;
    dp_rsp_ready = 1'b0;
    #1;
    chk("bp_release_dp_valid", 128'(dp_rsp_valid), 128'd0);
    chk("bp_release_ke_ready", 128'(ke_req_ready), 128'd1);
    step;
    ke_req_valid = 1'b0;
    #1;
    cnt = 0;
    while (!ke_rsp_valid && cnt < 40) begin step; #1; cnt++; end
    chk("bp_ke_result", 128'(ke_rsp_word), 128'h8a84eb01);
    step;
    dp_rsp_ready = 1'b1;
    repeat (3) step;

    // Reset during RUN cycle 7 of a DP request.
    step;
    dp_req_valid = 1'b1; dp_req_state = {$urandom, $urandom, $urandom, $urandom};
    #1;
    chk("mr_dp_accept", 128'(dp_req_ready), 128'd1);
    step;
    dp_req_valid = 1'b0;
    repeat (7) step;
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    #1;
    chk("mr_busy", 128'(busy), 128'd0);
    chk("mr_dp_rsp_valid", 128'(dp_rsp_valid), 128'd0);
    chk("mr_dp_rsp_state", dp_rsp_state, 128'd0);
    chk("mr_ke_rsp_word", 128'(ke_rsp_word), 128'd0);
    chk("mr_ke_rsp_valid", 128'(ke_rsp_valid), 128'd0);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      step; #1;
      if (dp_rsp_valid || busy) bad++;
    end
    chk("mr_no_late_response", 128'(bad), 128'd0);
    txn(1'b0, 128'h00000000, res, lat, busy_ok);
    chk("mr_fresh_ke", res, 128'h63636363);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
